// File: rtl/audio_clk_pkg.sv
// audio_clk_pkg: shared widths, types and increment helpers for audio_clock_divider
package audio_clk_pkg;
  localparam int ACC_W_DEFAULT = 32;
  typedef logic [ACC_W_DEFAULT-1:0] acc_t;
  function automatic longint unsigned calc_inc(input longint unsigned f_out, input longint unsigned f_clk);
    return ((f_out << ACC_W_DEFAULT) + (f_clk >> 1)) / f_clk;
  endfunction
  localparam acc_t INC_1024K = acc_t'(calc_inc(64'd1024000, 64'd100000000));
  localparam acc_t INC_64K = acc_t'(calc_inc(64'd64000, 64'd100000000));
  localparam acc_t INC_32K = acc_t'(calc_inc(64'd32000, 64'd100000000));
endpackage

// File: rtl/phase_acc_channel.sv
// phase_acc_channel: one phase accumulator producing a tick strobe, optional sq under CLKDIV_SQUARE_EN
module phase_acc_channel import audio_clk_pkg::*; #(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter logic [ACC_W-1:0] INC_DEFAULT = ACC_W'(INC_1024K)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_inc,
`ifdef CLKDIV_SQUARE_EN
  output logic             sq,
`endif
  output logic             tick,
  output logic             pend
);
  logic [ACC_W-1:0] acc, inc, inc_sh;
  logic [ACC_W:0] sum;
  assign sum = {1'b0, acc} + {1'b0, inc};
  // shadowed increments swap in only on overflow so no runt period is emitted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      inc <= INC_DEFAULT;
      inc_sh <= '0;
      pend <= 1'b0;
      tick <= 1'b0;
    end else if (sync) begin
      acc <= '0;
      tick <= 1'b0;
      inc <= wr ? wr_inc : pend ? inc_sh : inc;
      pend <= 1'b0;
    end else if (en) begin
      acc <= sum[ACC_W-1:0];
      tick <= sum[ACC_W];
      if (sum[ACC_W] && pend) begin
        inc <= inc_sh;
        pend <= 1'b0;
      end else if (wr) begin
        inc_sh <= wr_inc;
        pend <= 1'b1;
      end
    end else begin
      tick <= 1'b0;
      if (wr) inc <= wr_inc;
    end
  end
`ifdef CLKDIV_SQUARE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sq <= 1'b0;
    else if (sync) sq <= 1'b0;
    else if (en && sum[ACC_W]) sq <= ~sq;
  end
`endif
endmodule

// File: rtl/audio_clock_divider.sv
// audio_clock_divider: multi-channel fractional clock-enable generator; CLKDIV_SQUARE_EN adds sq outputs
module audio_clock_divider import audio_clk_pkg::*; #(
  parameter int NUM_CH = 3,
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter logic [ACC_W-1:0] INC_DEFAULT = ACC_W'(INC_1024K),
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
`ifdef CLKDIV_SQUARE_EN
  output logic [NUM_CH-1:0] sq,
`endif
  output logic [NUM_CH-1:0] tick
);
  logic [NUM_CH-1:0] pend;
  logic [(1<<CH_W)-1:0] pend_pad;
  logic accept;
  // unused channel codes read as never-pending, so writes to them are accepted and dropped
  always_comb begin
    pend_pad = '0;
    pend_pad[NUM_CH-1:0] = pend;
  end
  assign cfg_ready = !pend_pad[cfg_ch];
  assign accept = cfg_valid && cfg_ready;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    phase_acc_channel #(.ACC_W(ACC_W), .INC_DEFAULT(INC_DEFAULT)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .en(ch_en[c]),
      .sync(sync),
      .wr(accept && cfg_ch == CH_W'(c)),
      .wr_inc(cfg_inc),
`ifdef CLKDIV_SQUARE_EN
      .sq(sq[c]),
`endif
      .tick(tick[c]),
      .pend(pend[c])
    );
  end
endmodule
